// File: rtl/gp_timer.sv
// 16-bit general-purpose up-counter with prescaler, auto-reload, one-pulse mode
// and a sticky update flag exposed as a level interrupt.
module gp_timer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [15:0]      reg_wdata,
  output logic [15:0]      reg_rdata,
  output logic [CNT_W-1:0] tim_cnt,
  output logic             update_pulse,
  output logic             timer_interrupt
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic               cen_q, cen_d;
  logic               opm_q, opm_d;
  logic               uie_q, uie_d;
  logic               uif_q, uif_d;
  logic               pulse_q, pulse_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [PSC_W-1:0]   pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   arr_q, arr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               update;

  logic wr_ctrl, wr_psc, wr_arr, wr_status;
  assign wr_ctrl   = reg_we && (reg_addr == 2'd0);
  assign wr_psc    = reg_we && (reg_addr == 2'd1);
  assign wr_arr    = reg_we && (reg_addr == 2'd2);
  assign wr_status = reg_we && (reg_addr == 2'd3);

  always_comb begin
    state_d = state_q;
    cen_d   = cen_q;
    opm_d   = opm_q;
    uie_d   = uie_q;
    uif_d   = uif_q;
    psc_d   = psc_q;
    pcnt_d  = pcnt_q;
    arr_d   = arr_q;
    cnt_d   = cnt_q;
    update  = 1'b0;

    if (wr_ctrl) begin
      cen_d = reg_wdata[0];
      opm_d = reg_wdata[1];
      uie_d = reg_wdata[2];
    end
    if (wr_psc) psc_d = reg_wdata[PSC_W-1:0];
    if (wr_arr) arr_d = reg_wdata[CNT_W-1:0];

    // Compares use the registered PSC/ARR, so a same-cycle write applies next cycle.
    case (state_q)
      IDLE: begin
        if (wr_ctrl && reg_wdata[0]) begin
          state_d = RUN;
          pcnt_d  = '0;
        end
      end
      RUN: begin
        if (wr_ctrl && !reg_wdata[0]) begin
          state_d = IDLE;
        end else if (pcnt_q >= psc_q) begin
          pcnt_d = '0;
          if (cnt_q >= arr_q) begin
            update = 1'b1;
            cnt_d  = '0;
            if (opm_q) begin
              state_d = IDLE;
              cen_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          pcnt_d = pcnt_q + PSC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pulse_d = update;
    if (update) uif_d = 1'b1;
    else if (wr_status && reg_wdata[0]) uif_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cen_q   <= 1'b0;
      opm_q   <= 1'b0;
      uie_q   <= 1'b0;
      uif_q   <= 1'b0;
      pulse_q <= 1'b0;
      psc_q   <= '0;
      pcnt_q  <= '0;
      arr_q   <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cen_q   <= cen_d;
      opm_q   <= opm_d;
      uie_q   <= uie_d;
      uif_q   <= uif_d;
      pulse_q <= pulse_d;
      psc_q   <= psc_d;
      pcnt_q  <= pcnt_d;
      arr_q   <= arr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0:    reg_rdata = {13'd0, uie_q, opm_q, cen_q};
      2'd1:    reg_rdata = 16'(psc_q);
      2'd2:    reg_rdata = 16'(arr_q);
      default: reg_rdata = {15'd0, uif_q};
    endcase
  end

  assign tim_cnt         = cnt_q;
  assign update_pulse    = pulse_q;
  assign timer_interrupt = uif_q & uie_q;

endmodule

// File: tb/tb_gp_timer.sv
// Directed bench for gp_timer: a per-cycle reference model plus hand-computed
// expectations at the key points of each scenario.
module tb_gp_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic [15:0] tim_cnt;
  logic        update_pulse;
  logic        timer_interrupt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  gp_timer #(.CNT_W(16), .PSC_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .reg_we          (reg_we),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata),
    .tim_cnt         (tim_cnt),
    .update_pulse    (update_pulse),
    .timer_interrupt (timer_interrupt)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: timer state as plain integers, advanced once per clock.
  bit m_ok = 0;
  bit m_cen, m_opm, m_uie, m_uif, m_pulse;
  int unsigned m_psc, m_arr, m_pc, m_cnt;

  always @(posedge clk) begin
    bit upd, old_opm, ctrl_w, stop_w;
    if (reset) begin
      {m_cen, m_opm, m_uie, m_uif, m_pulse} = '0;
      m_psc = 0; m_arr = 16'hFFFF; m_pc = 0; m_cnt = 0;
      m_ok  = 1;
    end else begin
      upd     = 0;
      old_opm = m_opm;
      ctrl_w  = reg_we && reg_addr == 2'd0;
      stop_w  = ctrl_w && !reg_wdata[0];
      if (m_cen && !stop_w) begin
        if (m_pc >= m_psc) begin
          m_pc = 0;
          if (m_cnt >= m_arr) begin upd = 1; m_cnt = 0; end
          else m_cnt = m_cnt + 1;
        end else m_pc = m_pc + 1;
      end else if (!m_cen && ctrl_w && reg_wdata[0]) begin
        m_pc = 0;
      end
      if (ctrl_w) {m_uie, m_opm, m_cen} = reg_wdata[2:0];
      if (reg_we && reg_addr == 2'd1) m_psc = reg_wdata;
      if (reg_we && reg_addr == 2'd2) m_arr = reg_wdata;
      if (upd) begin
        m_uif = 1;
        if (old_opm) m_cen = 0;
      end else if (reg_we && reg_addr == 2'd3 && reg_wdata[0]) m_uif = 0;
      m_pulse = upd;
    end
  end

  function automatic logic [15:0] m_rd(logic [1:0] a);
    case (a)
      2'd0:    return {13'd0, m_uie, m_opm, m_cen};
      2'd1:    return 16'(m_psc);
      2'd2:    return 16'(m_arr);
      default: return {15'd0, m_uif};
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      check("mdl_cnt",   tim_cnt,         m_cnt);
      check("mdl_pulse", update_pulse,    m_pulse);
      check("mdl_irq",   timer_interrupt, m_uif & m_uie);
      check("mdl_rdata", reg_rdata,       m_rd(reg_addr));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    reg_we = 1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 0; reg_wdata = '0;
  endtask

  task automatic rd_check(string name, logic [1:0] a, logic [15:0] exp);
    reg_addr = a;
    #1;
    check(name, reg_rdata, exp);
  endtask

  task automatic do_reset(int n = 1);
    reset = 1;
    tick(n);
    reset = 0;
  endtask

  initial begin
    int pulses, cyc;
    reset = 1; reg_we = 0; reg_addr = 0; reg_wdata = 0;
    #1;
    tick(2);
    check("rst_cnt",   tim_cnt, 0);
    check("rst_irq",   timer_interrupt, 0);
    check("rst_pulse", update_pulse, 0);
    rd_check("rst_arr",  2'd2, 16'hFFFF);
    rd_check("rst_ctrl", 2'd0, 16'h0000);
    reset = 0;

    // Free-running wrap 0..3 with interrupt enabled.
    wr(1, 0); wr(2, 3); wr(0, 16'h5);
    check("t2_start", tim_cnt, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t2_cnt",   tim_cnt, i % 4);
      check("t2_pulse", update_pulse, (i % 4) == 0);
      check("t2_irq",   timer_interrupt, i >= 4);
    end

    // Prescaled count, first update 6 cycles after the enable edge.
    do_reset();
    wr(1, 2); wr(2, 1); wr(0, 16'h1);
    tick(3);
    check("t3_step", tim_cnt, 1);
    cyc = 3;
    while (!update_pulse && cyc < 20) begin tick(); cyc++; end
    check("t3_first_upd", cyc, 6);
    check("t3_irq", timer_interrupt, 0);

    // One-pulse mode.
    do_reset();
    wr(1, 0); wr(2, 2); wr(0, 16'h7);
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      pulses += update_pulse;
      check("t4_cnt", tim_cnt, (i < 3) ? i : 0);
    end
    check("t4_pulses", pulses, 1);
    rd_check("t4_ctrl", 2'd0, 16'h6);

    // Status clear racing a wrap, then a clean clear.
    do_reset();
    wr(1, 0); wr(2, 3); wr(0, 16'h5);
    tick(3);
    check("t5_pre", tim_cnt, 3);
    wr(3, 1);
    check("t5_race_pulse", update_pulse, 1);
    check("t5_race_irq",   timer_interrupt, 1);
    tick();
    wr(3, 1);
    check("t5_clr_irq", timer_interrupt, 0);
    rd_check("t5_status", 2'd3, 16'h0);

    // ARR=0: update on every tick, count pinned at 0.
    do_reset();
    wr(2, 0); wr(0, 16'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arr0_cnt",   tim_cnt, 0);
      check("arr0_pulse", update_pulse, 1);
    end

    // Lowered ARR below the running count, then reset mid-run.
    do_reset();
    wr(1, 3); wr(0, 16'h5);
    tick(20);
    check("t6_cnt5", tim_cnt, 5);
    wr(2, 3);
    tick(2);
    check("t6_hold", tim_cnt, 5);
    tick();
    check("t6_wrap_cnt",   tim_cnt, 0);
    check("t6_wrap_pulse", update_pulse, 1);
    tick(9);
    check("t6_irq_pre", timer_interrupt, 1);
    do_reset();
    check("t6_rst_cnt",   tim_cnt, 0);
    check("t6_rst_pulse", update_pulse, 0);
    check("t6_rst_irq",   timer_interrupt, 0);
    rd_check("t6_rst_ctrl", 2'd0, 16'h0);
    rd_check("t6_rst_psc",  2'd1, 16'h0);
    rd_check("t6_rst_arr",  2'd2, 16'hFFFF);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
